// File: rtl/weight_replay_buffer.sv
// Weight replay buffer: captures one DEPTH-word block, then replays it cfg_repeats times.
// Optional status_pass output when WEIGHT_REPLAY_PASSCNT_EN is defined.
module weight_replay_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 576,
  parameter int CNT_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [WIDTH-1:0] s_axis_w_tdata,
  input  logic             s_axis_w_tvalid,
  output logic             s_axis_w_tready,
  output logic [WIDTH-1:0] m_axis_w_tdata,
  output logic             m_axis_w_tvalid,
  input  logic             m_axis_w_tready,
  output logic             m_axis_w_tlast,
  input  logic [CNT_W-1:0] cfg_repeats,
  output logic             busy,
  output logic             block_done
`ifdef WEIGHT_REPLAY_PASSCNT_EN
  , output logic [CNT_W-1:0] status_pass
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    ADDR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {ST_LOAD = 1'b0, ST_REPLAY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             s_ready_q, s_ready_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [AW-1:0]    fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0] fetch_pass_q, fetch_pass_d;
  logic             fetch_done_q, fetch_done_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic load_hs_s, load_end_s, out_hs_s, final_hs_s;
  logic out_ready_s, rd_free_s, issue_s;

  always_comb begin
    load_hs_s   = (state_q == ST_LOAD) && s_ready_q && s_axis_w_tvalid;
    load_end_s  = load_hs_s && (wr_addr_q == LAST_ADDR);
    out_hs_s    = out_valid_q && m_axis_w_tready;
    final_hs_s  = out_hs_s && out_last_q && (pass_q == rep_q - CNT_ONE);
    out_ready_s = !out_valid_q || m_axis_w_tready;
    // The read register frees up whenever its word can move into the output register.
    rd_free_s   = !rd_valid_q || out_ready_s;
    issue_s     = (state_q == ST_REPLAY) && !fetch_done_q && rd_free_s;
  end

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rep_d        = rep_q;
    pass_d       = pass_q;
    fetch_addr_d = fetch_addr_q;
    fetch_pass_d = fetch_pass_q;
    fetch_done_d = fetch_done_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;

    case (state_q)
      ST_LOAD:   if (load_end_s) state_d = ST_REPLAY;
      ST_REPLAY: if (final_hs_s) state_d = ST_LOAD;
      default:   state_d = ST_LOAD;
    endcase
    s_ready_d = (state_d == ST_LOAD);

    if (load_hs_s) begin
      wr_addr_d = load_end_s ? '0 : wr_addr_q + ADDR_ONE;
      if (wr_addr_q == '0) begin
        rep_d = (cfg_repeats == '0) ? CNT_ONE : cfg_repeats;
      end
    end

    if (final_hs_s) begin
      pass_d = '0;
    end else if (out_hs_s && out_last_q) begin
      pass_d = pass_q + CNT_ONE;
    end

    if (load_end_s) begin
      fetch_addr_d = '0;
      fetch_pass_d = '0;
      fetch_done_d = 1'b0;
    end else if (issue_s) begin
      if (fetch_addr_q == LAST_ADDR) begin
        fetch_addr_d = '0;
        fetch_pass_d = fetch_pass_q + CNT_ONE;
        // Fetching stops after the final word of the final pass, so no stale pass leaks out.
        if (fetch_pass_q == rep_q - CNT_ONE) fetch_done_d = 1'b1;
      end else begin
        fetch_addr_d = fetch_addr_q + ADDR_ONE;
      end
    end

    if (rd_free_s) begin
      rd_valid_d = issue_s;
      rd_last_d  = issue_s && (fetch_addr_q == LAST_ADDR);
    end

    if (out_ready_s) begin
      out_valid_d = rd_valid_q;
      out_last_d  = rd_valid_q && rd_last_q;
      if (rd_valid_q) out_data_d = rd_data_q;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= ST_LOAD;
      s_ready_q    <= 1'b0;
      wr_addr_q    <= '0;
      rep_q        <= CNT_ONE;
      pass_q       <= '0;
      fetch_addr_q <= '0;
      fetch_pass_q <= '0;
      fetch_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      wr_addr_q    <= wr_addr_d;
      rep_q        <= rep_d;
      pass_q       <= pass_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_pass_q <= fetch_pass_d;
      fetch_done_q <= fetch_done_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
    end
  end

  // Block RAM: no reset, contents are only trusted once a full block has been loaded.
  always_ff @(posedge ap_clk) begin
    if (load_hs_s) mem[wr_addr_q] <= s_axis_w_tdata;
    if (issue_s)   rd_data_q      <= mem[fetch_addr_q];
  end

  assign s_axis_w_tready = s_ready_q;
  assign m_axis_w_tdata  = out_data_q;
  assign m_axis_w_tvalid = out_valid_q;
  assign m_axis_w_tlast  = out_last_q;
  assign busy            = (state_q == ST_REPLAY);
  assign block_done      = final_hs_s;
`ifdef WEIGHT_REPLAY_PASSCNT_EN
  assign status_pass     = pass_q;
`endif

endmodule

// File: tb/tb_weight_replay_buffer.sv
// Self-checking bench for weight_replay_buffer (DEPTH=4): queue-based reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_weight_replay_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic             m_tlast;
  logic [CNT_W-1:0] cfg_repeats = '0;
  logic             busy;
  logic             block_done;
`ifdef WEIGHT_REPLAY_PASSCNT_EN
  logic [CNT_W-1:0] status_pass;
`endif

  weight_replay_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .ap_clk(clk), .ap_rst(rst),
    .s_axis_w_tdata(s_tdata), .s_axis_w_tvalid(s_tvalid), .s_axis_w_tready(s_tready),
    .m_axis_w_tdata(m_tdata), .m_axis_w_tvalid(m_tvalid), .m_axis_w_tready(m_tready),
    .m_axis_w_tlast(m_tlast), .cfg_repeats(cfg_repeats), .busy(busy), .block_done(block_done)
`ifdef WEIGHT_REPLAY_PASSCNT_EN
    , .status_pass(status_pass)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic chk_en = 1'b0;
  logic bp = 1'b0;

  typedef struct packed {logic [7:0] d; logic last; logic done;} exp_t;
  exp_t exp_q[$];
  logic [7:0] mdl_mem [DEPTH];
  int ld_cnt = 0;
  int rep_eff = 1;
  logic model_load = 1'b1;
  int pass_idx = 0;
  int done_cnt = 0;

  logic [7:0] out_log[$];
  int last_idx[$];
  int st_log[$];
  int done_idx = 0;
  int done_cyc = 0;
  int first_valid_cyc = 0;
  logic seen_valid = 1'b0;
  int load_edge = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    out_log.delete();
    last_idx.delete();
    st_log.delete();
    done_idx = 0;
    seen_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference model and per-cycle compare, sampled mid-cycle on the falling edge.
  initial forever begin
    logic ml;
    exp_t f;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      ld_cnt = 0;
      model_load = 1'b1;
      pass_idx = 0;
    end else if (chk_en) begin
      ml = model_load;
      chk("s_tready", 32'(s_tready), 32'(ml));
      chk("busy", 32'(busy), 32'(!ml));
`ifdef WEIGHT_REPLAY_PASSCNT_EN
      chk("status_pass", 32'(status_pass), ml ? 32'd0 : 32'(pass_idx));
`endif
      if (m_tvalid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          first_valid_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
          chk("spurious_tvalid", 32'(m_tvalid), 32'd0);
        end else begin
          f = exp_q[0];
          chk("m_tdata", 32'(m_tdata), 32'(f.d));
          chk("m_tlast", 32'(m_tlast), 32'(f.last));
          if (m_tready) begin
            chk("block_done", 32'(block_done), 32'(f.done));
            out_log.push_back(m_tdata);
`ifdef WEIGHT_REPLAY_PASSCNT_EN
            st_log.push_back(int'(status_pass));
`endif
            if (f.last) begin
              last_idx.push_back(out_log.size());
              pass_idx++;
            end
            if (f.done) begin
              done_idx = out_log.size();
              done_cyc = cyc;
              done_cnt++;
              pass_idx = 0;
              model_load = 1'b1;
            end
            void'(exp_q.pop_front());
          end else begin
            chk("block_done_stall", 32'(block_done), 32'd0);
          end
        end
      end else begin
        chk("block_done_idle", 32'(block_done), 32'd0);
      end
      if (s_tvalid && ml) begin
        if (ld_cnt == 0) rep_eff = (cfg_repeats == '0) ? 1 : int'(cfg_repeats);
        mdl_mem[ld_cnt] = s_tdata;
        ld_cnt++;
        if (ld_cnt == DEPTH) begin
          for (int p = 0; p < rep_eff; p++)
            for (int i = 0; i < DEPTH; i++)
              exp_q.push_back('{mdl_mem[i], (i == DEPTH-1), (i == DEPTH-1) && (p == rep_eff-1)});
          ld_cnt = 0;
          model_load = 1'b0;
          seen_valid = 1'b0;
          load_edge = cyc + 1;
        end
      end
    end
  end

  task automatic load_block(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3,
                            input logic [CNT_W-1:0] rep);
    logic [7:0] w [4];
    logic acc;
    int t;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      s_tdata = w[i];
      s_tvalid = 1'b1;
      if (i == 0) cfg_repeats = rep;
      t = 0;
      acc = 1'b0;
      while (!acc && t < 50) begin
        @(negedge clk);
        acc = s_tready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) chk("load_timeout", 32'd0, 32'd1);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    int t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == start) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
    chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_m_tlast"}, 32'(m_tlast), 32'd0);
    chk({tag, "_m_tdata"}, 32'(m_tdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_block_done"}, 32'(block_done), 32'd0);
  endtask

  initial begin
    logic [7:0] t1 [12];
    int t;
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("tready_after_reset", 32'(s_tready), 32'd1);
    chk_en = 1'b1;

    // Plain load/replay with full-rate consumer.
    clear_logs();
    load_block(8'h11, 8'h22, 8'h33, 8'h44, 16'd3);
    wait_done();
    chk("t1_count", 32'(out_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < out_log.size(); i++) chk("t1_word", 32'(out_log[i]), 32'(t1[i]));
    chk("t1_nlast", 32'(last_idx.size()), 32'd3);
    if (last_idx.size() == 3) begin
      chk("t1_last0", 32'(last_idx[0]), 32'd4);
      chk("t1_last1", 32'(last_idx[1]), 32'd8);
      chk("t1_last2", 32'(last_idx[2]), 32'd12);
    end
    chk("t1_done_idx", 32'(done_idx), 32'd12);
    chk("t1_no_bubble", 32'(done_cyc - first_valid_cyc), 32'd11);
    chk("t1_latency", 32'(first_valid_cyc), 32'(load_edge + 2));
`ifdef WEIGHT_REPLAY_PASSCNT_EN
    for (int i = 0; i < 12 && i < st_log.size(); i++) chk("t1_status_pass", 32'(st_log[i]), 32'(i / 4));
    chk("t1_status_after", 32'(status_pass), 32'd0);
`endif

    // Random consumer backpressure.
    clear_logs();
    bp = 1'b1;
    load_block(8'h01, 8'h02, 8'h03, 8'h04, 16'd2);
    wait_done();
    bp = 1'b0;
    chk("bp_count", 32'(out_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) chk("bp_word", 32'(out_log[i]), 32'((i % 4) + 1));

    // cfg_repeats == 0 gives one pass.
    clear_logs();
    load_block(8'hB0, 8'hB1, 8'hB2, 8'hB3, 16'd0);
    wait_done();
    chk("rep0_count", 32'(out_log.size()), 32'd4);

    // Changing cfg_repeats mid-replay does not extend the block.
    clear_logs();
    load_block(8'hC0, 8'hC1, 8'hC2, 8'hC3, 16'd2);
    cfg_repeats = 16'd5;
    wait_done();
    chk("midcfg_count", 32'(out_log.size()), 32'd8);

    // Reset during pass 1, word 2.
    clear_logs();
    load_block(8'hD0, 8'hD1, 8'hD2, 8'hD3, 16'd3);
    t = 0;
    while (out_log.size() < 6 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (out_log.size() < 6) chk("midrst_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("tready_after_midrst", 32'(s_tready), 32'd1);
    chk_en = 1'b1;
    clear_logs();
    load_block(8'hA0, 8'hA1, 8'hA2, 8'hA3, 16'd1);
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    chk("newblk_count", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) chk("newblk_word", 32'(out_log[i]), 32'(8'hA0 + i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
